// File: rtl/counter_tick_div.sv
// Up/down counter stepped by an internal clock-enable prescaler. Everything is in
// the clk domain, and tick/tc are registered single-cycle strobes.
module counter_tick_div #(
  parameter int WIDTH = 4,
  parameter int DIV   = 50000000,
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] counter_out,
  output logic             tick,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             step;

  function automatic logic at_bound(input logic [WIDTH-1:0] cnt, input logic up);
    return up ? (cnt == MAX_VAL) : (cnt == '0);
  endfunction

  // Wrap or saturate at the bounds; the arithmetic itself is modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] cnt,
                                                  input logic up, input logic sat);
    if (at_bound(cnt, up) && sat)
      return cnt;
    return up ? cnt + 1'b1 : cnt - 1'b1;
  endfunction

  assign step = en && !load && (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      counter_out <= '0;
      tick        <= 1'b0;
      tc          <= 1'b0;
    end else if (load) begin
      div_cnt     <= '0;
      counter_out <= load_val;
      tick        <= 1'b0;
      tc          <= 1'b0;
    end else if (step) begin
      div_cnt     <= '0;
      counter_out <= next_count(counter_out, up_dn, sat_mode);
      tick        <= 1'b1;
      tc          <= at_bound(counter_out, up_dn);
    end else begin
      // Disabled cycles freeze prescaler progress rather than resetting it.
      if (en)
        div_cnt <= div_cnt + 1'b1;
      tick <= 1'b0;
      tc   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_tick_div.sv
// Directed bench for counter_tick_div: a DIV=4 instance for the main scenarios and
// a DIV=1 instance for the every-cycle stepping case, both checked via scoreboards.
module tb_counter_tick_div;

  typedef struct packed {
    logic [3:0] cnt;
    logic       tick;
    logic       tc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, sat_mode, load;
  logic [3:0] load_val;
  logic [3:0] counter_out, counter_out1;
  logic       tick, tc, tick1, tc1;

  exp_t q[$];
  exp_t q1[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  counter_tick_div #(.WIDTH(4), .DIV(4), .DIV_W(3)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val),
    .counter_out(counter_out), .tick(tick), .tc(tc)
  );

  counter_tick_div #(.WIDTH(4), .DIV(1), .DIV_W(3)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val),
    .counter_out(counter_out1), .tick(tick1), .tc(tc1)
  );

  // One clock on the DIV=4 instance: expectation queued with the stimulus, checked after the edge.
  task automatic cyc(input string tag, input logic [3:0] c, input logic t, input logic k);
    exp_t e;
    q.push_back(exp_t'({c, t, k}));
    @(posedge clk);
    #1;
    e = q.pop_front();
    checks++;
    assert ({counter_out, tick, tc} === e) passed++;
    else $error("FAIL %s: got cnt=%0d tick=%b tc=%b, expected cnt=%0d tick=%b tc=%b",
                tag, counter_out, tick, tc, e.cnt, e.tick, e.tc);
  endtask

  task automatic cyc1(input string tag, input logic [3:0] c, input logic t, input logic k);
    exp_t e;
    q1.push_back(exp_t'({c, t, k}));
    @(posedge clk);
    #1;
    e = q1.pop_front();
    checks++;
    assert ({counter_out1, tick1, tc1} === e) passed++;
    else $error("FAIL %s: got cnt=%0d tick=%b tc=%b, expected cnt=%0d tick=%b tc=%b",
                tag, counter_out1, tick1, tc1, e.cnt, e.tick, e.tc);
  endtask

  // A full DIV=4 step period: three hold cycles, then the step edge.
  task automatic period(input string tag, input logic [3:0] hold_v, input logic [3:0] new_v,
                        input logic new_tc);
    for (int i = 0; i < 3; i++) cyc({tag, "_hold"}, hold_v, 1'b0, 1'b0);
    cyc({tag, "_step"}, new_v, 1'b1, new_tc);
  endtask

  task automatic do_load(input string tag, input logic [3:0] v);
    load = 1'b1; load_val = v;
    cyc(tag, v, 1'b0, 1'b0);
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; sat_mode = 1'b0; load = 1'b0; load_val = '0;
    for (int i = 0; i < 3; i++) cyc("reset", 4'd0, 1'b0, 1'b0);

    rst = 1'b0; en = 1'b1;
    period("first", 4'd0, 4'd1, 1'b0);
    period("second", 4'd1, 4'd2, 1'b0);

    do_load("ld14_wrap", 4'd14);
    period("up_wrap_a", 4'd14, 4'd15, 1'b0);
    period("up_wrap_b", 4'd15, 4'd0, 1'b1);

    sat_mode = 1'b1;
    do_load("ld14_sat", 4'd14);
    period("up_sat_a", 4'd14, 4'd15, 1'b0);
    period("up_sat_b", 4'd15, 4'd15, 1'b1);
    period("up_sat_c", 4'd15, 4'd15, 1'b1);

    up_dn = 1'b0;
    do_load("ld2_sat", 4'd2);
    period("dn_sat_a", 4'd2, 4'd1, 1'b0);
    period("dn_sat_b", 4'd1, 4'd0, 1'b0);
    period("dn_sat_c", 4'd0, 4'd0, 1'b1);

    sat_mode = 1'b0;
    do_load("ld2_wrap", 4'd2);
    period("dn_wrap_a", 4'd2, 4'd1, 1'b0);
    period("dn_wrap_b", 4'd1, 4'd0, 1'b0);
    period("dn_wrap_c", 4'd0, 4'd15, 1'b1);

    up_dn = 1'b1;
    do_load("ld5", 4'd5);
    cyc("pre_mid_a", 4'd5, 1'b0, 1'b0);
    cyc("pre_mid_b", 4'd5, 1'b0, 1'b0);
    do_load("ld9_mid", 4'd9);
    period("after_mid", 4'd9, 4'd10, 1'b0);

    en = 1'b0;
    do_load("ld3_noen", 4'd3);
    cyc("noen_hold_a", 4'd3, 1'b0, 1'b0);
    cyc("noen_hold_b", 4'd3, 1'b0, 1'b0);
    en = 1'b1;
    period("after_noen", 4'd3, 4'd4, 1'b0);

    cyc("gap_pre_a", 4'd4, 1'b0, 1'b0);
    cyc("gap_pre_b", 4'd4, 1'b0, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 10; i++) cyc("gap_frozen", 4'd4, 1'b0, 1'b0);
    en = 1'b1;
    cyc("gap_post_a", 4'd4, 1'b0, 1'b0);
    cyc("gap_post_b", 4'd5, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++) cyc("pre_rst_ld", 4'd5, 1'b0, 1'b0);
    rst = 1'b1; load = 1'b1; load_val = 4'd7;
    cyc("rst_over_load", 4'd0, 1'b0, 1'b0);
    rst = 1'b0; load = 1'b0;
    period("after_rst", 4'd0, 4'd1, 1'b0);

    rst = 1'b1;
    cyc1("div1_reset", 4'd0, 1'b0, 1'b0);
    rst = 1'b0; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
    for (int i = 1; i <= 17; i++)
      cyc1("div1_up", 4'(i % 16), 1'b1, (i == 16));
    en = 1'b0;
    cyc1("div1_noen", 4'd1, 1'b0, 1'b0);
    en = 1'b1; up_dn = 1'b0;
    cyc1("div1_dn_a", 4'd0, 1'b1, 1'b0);
    cyc1("div1_dn_b", 4'd15, 1'b1, 1'b1);
    load = 1'b1; load_val = 4'd8;
    cyc1("div1_load", 4'd8, 1'b0, 1'b0);
    load = 1'b0;
    cyc1("div1_after_ld", 4'd7, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
